// File: rtl/mutex_arb_pkg.sv
// Shared types and reset constants for the round-robin mutual-exclusion arbiter.
package mutex_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam arb_state_e ST_RST     = IDLE;
    localparam int         RR_PTR_RST = 0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or above i_ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_elig,
    input  logic [IDW-1:0]   i_ptr,
    output logic             o_found,
    output logic [IDW-1:0]   o_idx
);

    localparam int SW = IDW + 1;

    logic [N_REQ-1:0] w_rot;
    logic [IDW-1:0]   w_pos;
    logic [SW-1:0]    w_sum;

    // Rotating right by i_ptr puts rr_ptr at bit 0, so the lowest set bit wins.
    assign w_rot = N_REQ'({i_elig, i_elig} >> i_ptr);

    always_comb begin
        o_found = 1'b0;
        w_pos   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_found = 1'b1;
                w_pos   = IDW'(i);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, w_pos} + {1'b0, i_ptr};
        if (w_sum >= SW'(N_REQ))
            w_sum = w_sum - SW'(N_REQ);
        o_idx = w_sum[IDW-1:0];
    end

endmodule

// File: rtl/mutex_grant_arbiter.sv
// Round-robin single-owner arbiter with break-before-make gap, hold limit and forced revoke.
module mutex_grant_arbiter
    import mutex_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IDW = $clog2(N_REQ);
    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    localparam logic [HCW-1:0] HOLD_LIM = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_SAT = '1;
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N_REQ - 1);

    arb_state_e       r_state, w_nxt_state;
    logic [IDW-1:0]   r_rr_ptr, w_nxt_ptr;
    logic [N_REQ-1:0] r_blocked, w_nxt_blk;
    logic [HCW-1:0]   r_hold_cnt, w_nxt_hold;
    logic [GCW-1:0]   r_gap_cnt, w_nxt_gap;
    logic [N_REQ-1:0] r_gnt, w_nxt_gnt;
    logic [IDW-1:0]   r_gnt_id, w_nxt_id;
    logic             r_busy;
    logic             r_timeout, w_nxt_to;

    logic             w_arb;
    logic             w_found;
    logic [IDW-1:0]   w_pick;
    logic [IDW-1:0]   w_own_nxt;
    logic             w_hold_hit;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .i_elig  (req & ~r_blocked),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_own_nxt  = (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + IDW'(1);
    assign w_hold_hit = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIM);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_rr_ptr;
        w_nxt_blk   = r_blocked & req;
        w_nxt_hold  = r_hold_cnt;
        w_nxt_gap   = r_gap_cnt;
        w_nxt_gnt   = r_gnt;
        w_nxt_id    = r_gnt_id;
        w_nxt_to    = 1'b0;
        w_arb       = 1'b0;

        case (r_state)
            IDLE: w_arb = 1'b1;
            GRANT: begin
                if (req[r_gnt_id] && !w_hold_hit) begin
                    if (r_hold_cnt != HOLD_SAT)
                        w_nxt_hold = r_hold_cnt + HCW'(1);
                end else begin
                    w_nxt_gnt   = '0;
                    w_nxt_ptr   = w_own_nxt;
                    w_nxt_gap   = '0;
                    w_nxt_state = GAP;
                    // A drop on the limit cycle is an ordinary release, not a revoke.
                    if (req[r_gnt_id]) begin
                        w_nxt_to            = 1'b1;
                        w_nxt_blk[r_gnt_id] = 1'b1;
                    end
                end
            end
            GAP: begin
                // The last gap cycle arbitrates so gnt is low for exactly GAP_CYCLES cycles.
                if (r_gap_cnt == GAP_LAST) begin
                    w_arb       = 1'b1;
                    w_nxt_state = IDLE;
                end else begin
                    w_nxt_gap = r_gap_cnt + GCW'(1);
                end
            end
            default: w_nxt_state = IDLE;
        endcase

        if (w_arb && w_found) begin
            w_nxt_gnt   = N_REQ'(1) << w_pick;
            w_nxt_id    = w_pick;
            w_nxt_hold  = HCW'(1);
            w_nxt_state = GRANT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RST;
            r_rr_ptr   <= IDW'(RR_PTR_RST);
            r_blocked  <= '0;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_rr_ptr   <= w_nxt_ptr;
            r_blocked  <= w_nxt_blk;
            r_hold_cnt <= w_nxt_hold;
            r_gap_cnt  <= w_nxt_gap;
            r_gnt      <= w_nxt_gnt;
            r_gnt_id   <= w_nxt_id;
            r_busy     <= |w_nxt_gnt;
            r_timeout  <= w_nxt_to;
        end
    end

    assign gnt         = r_gnt;
    assign gnt_id      = r_gnt_id;
    assign busy        = r_busy;
    assign timeout_err = r_timeout;

    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(r_gnt));
            assert (r_busy == |r_gnt);
            assert (r_gnt == '0 || r_state == GRANT);
        end
    end

endmodule

// File: tb/tb_mutex_grant_arbiter.sv
// Directed and random checks of mutex_grant_arbiter (N_REQ=2, MAX_HOLD=4, GAP_CYCLES=1).
module tb_mutex_grant_arbiter;

    localparam int N_REQ   = 2;
    localparam int MAX_H   = 4;
    localparam int GAP_C   = 1;
    localparam int LAT_MAX = 2 * (MAX_H + GAP_C + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b11;
    logic [1:0] gnt;
    logic       gnt_id;
    logic       busy;
    logic       timeout_err;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #10 clk = ~clk;

    mutex_grant_arbiter #(
        .N_REQ      (N_REQ),
        .MAX_HOLD   (MAX_H),
        .GAP_CYCLES (GAP_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Holds reset for two cycles with the given req, releasing it on a negedge.
    task automatic apply_reset(input logic [1:0] r);
        @(negedge clk);
        rst = 1'b1;
        req = r;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b11;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tot_cnt++;
            if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt);
            else pass_cnt++;
            tot_cnt++;
            if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
            else pass_cnt++;
            tot_cnt++;
            if (timeout_err !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_err);
            else pass_cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if (gnt !== 2'b01) $display("FAIL reset_first_gnt: got %b want 01", gnt);
        else pass_cnt++;
        tot_cnt++;
        if (gnt_id !== 1'b0 || busy !== 1'b1)
            $display("FAIL reset_first_id_busy: got id=%b busy=%b want id=0 busy=1", gnt_id, busy);
        else pass_cnt++;
    endtask

    task automatic test_alternation();
        logic [1:0] exp_g [7] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
        logic [1:0] drv   [7] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
        apply_reset(2'b11);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            tot_cnt++;
            if (gnt !== exp_g[k]) $display("FAIL alt_gnt[%0d]: got %b want %b", k, gnt, exp_g[k]);
            else pass_cnt++;
            req = drv[k];
        end
    endtask

    task automatic test_timeout();
        logic [1:0] exp_g [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                   2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic       exp_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        apply_reset(2'b01);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tot_cnt++;
            if (gnt !== exp_g[k] || timeout_err !== exp_t[k])
                $display("FAIL timeout_seq[%0d]: got gnt=%b to=%b want gnt=%b to=%b",
                         k, gnt, timeout_err, exp_g[k], exp_t[k]);
            else pass_cnt++;
        end
        req = 2'b00;
        @(negedge clk);
        tot_cnt++;
        if (gnt !== 2'b00) $display("FAIL timeout_drop_gnt: got %b want 00", gnt);
        else pass_cnt++;
        req = 2'b01;
        @(negedge clk);
        tot_cnt++;
        if (gnt !== 2'b01 || timeout_err !== 1'b0)
            $display("FAIL timeout_regrant: got gnt=%b to=%b want gnt=01 to=0", gnt, timeout_err);
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        apply_reset(2'b01);
        repeat (4) @(negedge clk);
        tot_cnt++;
        if (gnt !== 2'b01) $display("FAIL bound_hold: got %b want 01", gnt);
        else pass_cnt++;
        req = 2'b00;
        @(negedge clk);
        tot_cnt++;
        if (gnt !== 2'b00 || timeout_err !== 1'b0)
            $display("FAIL bound_release: got gnt=%b to=%b want gnt=00 to=0", gnt, timeout_err);
        else pass_cnt++;
        req = 2'b01;
        @(negedge clk);
        tot_cnt++;
        if (gnt !== 2'b01 || timeout_err !== 1'b0)
            $display("FAIL bound_not_blocked: got gnt=%b to=%b want gnt=01 to=0", gnt, timeout_err);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        apply_reset(2'b01);
        @(negedge clk);
        req = 2'b10;
        @(negedge clk);
        @(negedge clk);
        tot_cnt++;
        if (gnt !== 2'b10) $display("FAIL async_pre_gnt: got %b want 10", gnt);
        else pass_cnt++;
        #5;
        rst = 1'b1;
        req = 2'b11;
        #1;
        tot_cnt++;
        if (gnt !== 2'b00 || busy !== 1'b0)
            $display("FAIL async_drop: got gnt=%b busy=%b want gnt=00 busy=0", gnt, busy);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if (gnt !== 2'b01 || gnt_id !== 1'b0)
            $display("FAIL async_restart: got gnt=%b id=%b want gnt=01 id=0", gnt, gnt_id);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int   wt  [2] = '{0, 0};
        int   run [2] = '{0, 0};
        logic blk [2] = '{1'b0, 1'b0};
        int   oh_viol  = 0;
        int   lat_viol = 0;
        apply_reset(2'b00);
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (gnt == 2'b11 || busy !== (|gnt)) oh_viol++;
            for (int i = 0; i < 2; i++) begin
                if (!gnt[i] && run[i] == MAX_H && req[i]) blk[i] = 1'b1;
                if (!req[i]) blk[i] = 1'b0;
                run[i] = gnt[i] ? run[i] + 1 : 0;
                if (req[i] && !gnt[i] && !blk[i]) wt[i]++;
                else wt[i] = 0;
                if (wt[i] > LAT_MAX) begin
                    lat_viol++;
                    wt[i] = 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req[i]) req[i] = ($urandom_range(5) != 0);
                else        req[i] = ($urandom_range(2) == 0);
            end
        end
        tot_cnt++;
        if (oh_viol !== 0) $display("FAIL rand_onehot: got %0d violations want 0", oh_viol);
        else pass_cnt++;
        tot_cnt++;
        if (lat_viol !== 0) $display("FAIL rand_latency: got %0d starved waits want 0", lat_viol);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_timeout();
        test_boundary();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
